// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Load/store sequencer between the RV32E execute stage and memory_group. It
// takes one request at a time, checks it for faults, drives the single-cycle
// synchronous memory port, extends load data and returns one response per
// request.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake (ready only when idle)
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V funct3 (size and signedness)
//   req_addr          byte address
//   req_wdata         right-justified store data
//   req_rd            destination tag, returned unchanged in resp_rd
//   resp_valid/ready  response handshake
//   resp_data         extended load data, 0 for stores and faults
//   resp_fault        illegal funct3 or out-of-range access
//   resp_rd           tag of the request being answered
//   mem_write_mask    byte write enables to memory_group
//   mem_addr          byte address to memory_group
//   mem_write_data    unshifted store data to memory_group
//   mem_read_data     read data, valid one cycle after mem_addr
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DATA_DEPTH = 4096,
    localparam int ADDR_W = 2 + $clog2(DATA_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_rd,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [3:0]        resp_rd,
    output logic [3:0]        mem_write_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    // Highest legal byte address, held in 33 bits so the end-of-access sum
    // below cannot wrap and any nonzero upper address bits also fault.
    localparam logic [32:0] LAST_BYTE = 33'(4 * DATA_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StLoadWait,
        StResp
    } state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_funct3;

    logic [32:0] access_size;
    logic [32:0] end_byte;
    logic        funct3_bad;
    logic        range_bad;
    logic        req_fault;
    logic [3:0]  store_mask;
    logic [31:0] load_data;

    assign req_ready  = (state == StIdle);
    assign resp_valid = (state == StResp);

    // ------------------------------------------------------------------
    // Accept-time decode: size, fault detection, byte mask
    // ------------------------------------------------------------------
    always_comb begin
        access_size = 33'd4;
        store_mask  = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                access_size = 33'd1;
                store_mask  = 4'b0001;
            end
            2'b01: begin
                access_size = 33'd2;
                store_mask  = 4'b0011;
            end
            default: begin
                access_size = 33'd4;
                store_mask  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        if (req_we) begin
            // Only SB/SH/SW exist.
            funct3_bad = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            // 011, 110 and 111 are not loads.
            funct3_bad = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
        end
    end

    assign end_byte  = {1'b0, req_addr} + access_size - 33'd1;
    assign range_bad = (end_byte > LAST_BYTE);
    assign req_fault = funct3_bad | range_bad;

    // ------------------------------------------------------------------
    // Load result extension, based on the latched funct3
    // ------------------------------------------------------------------
    always_comb begin
        load_data = mem_read_data;
        case (lat_funct3)
            3'b000:  load_data = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
            3'b001:  load_data = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
            3'b100:  load_data = {24'h000000, mem_read_data[7:0]};
            3'b101:  load_data = {16'h0000, mem_read_data[15:0]};
            default: load_data = mem_read_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs. The write mask is only ever set
    // on the way into StAccess and cleared on the way out, so reset drops
    // it immediately and aborts any store that has not yet committed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            lat_we         <= 1'b0;
            lat_funct3     <= 3'b000;
            resp_data      <= 32'h0;
            resp_fault     <= 1'b0;
            resp_rd        <= 4'h0;
            mem_write_mask <= 4'b0000;
            mem_addr       <= '0;
            mem_write_data <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        lat_we     <= req_we;
                        lat_funct3 <= req_funct3;
                        resp_rd    <= req_rd;
                        resp_data  <= 32'h0;
                        if (req_fault) begin
                            resp_fault <= 1'b1;
                            state      <= StResp;
                        end else begin
                            resp_fault     <= 1'b0;
                            mem_addr       <= req_addr[ADDR_W-1:0];
                            mem_write_data <= req_wdata;
                            mem_write_mask <= req_we ? store_mask : 4'b0000;
                            state          <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    // A store commits at this edge; a load's read is launched.
                    mem_write_mask <= 4'b0000;
                    state          <= lat_we ? StResp : StLoadWait;
                end
                StLoadWait: begin
                    resp_data <= load_data;
                    state     <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A byte-addressed memory stands in
// for memory_group (one-cycle read, byte-masked write, misaligned access
// wrapping within the array). Directed table vectors and hand sequences are
// followed by randomized traffic checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int DEPTH  = 4096;
    localparam int AW     = 2 + $clog2(DEPTH);
    localparam int NBYTES = 4 * DEPTH;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_rd;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic          resp_fault;
    logic [3:0]    resp_rd;
    logic [3:0]    mem_write_mask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;

    int checks = 0;
    int errors = 0;

    load_store_unit #(
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rd         (req_rd),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault),
        .resp_rd        (resp_rd),
        .mem_write_mask (mem_write_mask),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // ---------------- memory_group stand-in ----------------
    logic [7:0] env_mem [NBYTES];
    logic       init_mem;
    int         env_a;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NBYTES; i++) env_mem[i] <= pat(i);
            mem_read_data <= 32'h0;
        end else begin
            env_a = int'(mem_addr);
            mem_read_data <= {env_mem[(env_a + 3) % NBYTES], env_mem[(env_a + 2) % NBYTES],
                              env_mem[(env_a + 1) % NBYTES], env_mem[env_a % NBYTES]};
            for (int i = 0; i < 4; i++) begin
                if (mem_write_mask[i]) env_mem[(env_a + i) % NBYTES] <= mem_write_data[8*i +: 8];
            end
        end
    end

    // Counts cycles with any write enable, and remembers the last mask seen.
    int         mask_total = 0;
    logic [3:0] mask_last  = 4'h0;

    always @(negedge clk) begin
        if (mem_write_mask != 4'h0) begin
            mask_total = mask_total + 1;
            mask_last  = mem_write_mask;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [NBYTES];

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] edata,
                         output logic efault, output int elat, output logic [3:0] emask);
        int     size;
        int     base;
        logic   legal;
        longint last;
        longint val;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2})
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        last  = longint'({32'h0, addr}) + longint'(size) - 1;
        edata = 32'h0;
        emask = 4'h0;
        if (!legal || last > longint'(NBYTES - 1)) begin
            efault = 1'b1;
            elat   = 1;
        end else begin
            efault = 1'b0;
            base   = int'(addr);
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
                elat  = 2;
                emask = 4'((1 << size) - 1);
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(ref_mem[base + i]) << (8 * i);
                if (!f3[2] && size < 4 && val[8*size-1]) val -= longint'(1) << (8 * size);
                edata = val[31:0];
                elat  = 3;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, optionally stall the response, complete the handshake.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] rd, input int stall,
                           output logic [31:0] d, output logic f, output logic [3:0] r,
                           output int lat, output int mcnt, output logic [3:0] mval,
                           output logic rdy_after);
        int m0;
        int n;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        m0 = mask_total;
        @(posedge clk); #1;
        // Scramble the request bus to make sure the unit works from its latches.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 4'($urandom);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) chk("response timeout", 32'(resp_valid), 32'h1);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
        end
        d = resp_data;
        f = resp_fault;
        r = resp_rd;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        rdy_after = req_ready & ~resp_valid;
        mcnt = mask_total - m0;
        mval = mask_last;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic [31:0] edata;
        logic        efault;
        logic [3:0]  emask;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] rd, input logic [31:0] edata,
                       input logic efault, input logic [3:0] emask);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.edata = edata; v.efault = efault; v.emask = emask;
        vecs.push_back(v);
    endtask

    logic [31:0] d, md;
    logic        f, mf, rdy;
    logic [3:0]  r, mval, mm;
    int          lat, mlat, mcnt;

    initial begin
        //  we    f3    addr           wdata          rd    edata          flt   mask
        add(1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 4'd1, 32'h0000_0000, 1'b0, 4'hF);
        add(1'b0, 3'd2, 32'h0000_0010, 32'h0,        4'd2, 32'hDEADBEEF, 1'b0, 4'h0);
        add(1'b0, 3'd0, 32'h0000_0013, 32'h0,        4'd3, 32'hFFFFFFDE, 1'b0, 4'h0);
        add(1'b0, 3'd4, 32'h0000_0013, 32'h0,        4'd4, 32'h000000DE, 1'b0, 4'h0);
        add(1'b0, 3'd5, 32'h0000_0011, 32'h0,        4'd5, 32'h0000ADBE, 1'b0, 4'h0);
        add(1'b0, 3'd1, 32'h0000_0012, 32'h0,        4'd6, 32'hFFFFDEAD, 1'b0, 4'h0);
        add(1'b1, 3'd2, 32'h0000_0000, 32'h11223344, 4'd7, 32'h0000_0000, 1'b0, 4'hF);
        add(1'b1, 3'd2, 32'h0000_0004, 32'h55667788, 4'd8, 32'h0000_0000, 1'b0, 4'hF);
        add(1'b1, 3'd1, 32'h0000_0003, 32'h0000CAFE, 4'd9, 32'h0000_0000, 1'b0, 4'h3);
        add(1'b0, 3'd2, 32'h0000_0000, 32'h0,        4'd10, 32'hFE223344, 1'b0, 4'h0);
        add(1'b0, 3'd2, 32'h0000_0004, 32'h0,        4'd11, 32'h556677CA, 1'b0, 4'h0);
        add(1'b0, 3'd2, 32'h0000_3FFE, 32'h0,        4'd12, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b0, 3'd3, 32'h0000_0020, 32'h0,        4'd13, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b1, 3'd3, 32'h0000_0020, 32'h12345678, 4'd14, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b1, 3'd4, 32'h0000_0020, 32'h12345678, 4'd15, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b0, 3'd0, 32'h0001_0000, 32'h0,        4'd1, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b1, 3'd2, 32'h0000_3FFC, 32'h80000000, 4'd2, 32'h0000_0000, 1'b0, 4'hF);
        add(1'b0, 3'd0, 32'h0000_3FFF, 32'h0,        4'd3, 32'hFFFFFF80, 1'b0, 4'h0);
        add(1'b0, 3'd4, 32'h0000_3FFF, 32'h0,        4'd4, 32'h00000080, 1'b0, 4'h0);
        add(1'b0, 3'd1, 32'h0000_3FFF, 32'h0,        4'd5, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b1, 3'd2, 32'h0000_3FFE, 32'h12345678, 4'd6, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b0, 3'd2, 32'h0000_3FFC, 32'h0,        4'd7, 32'h80000000, 1'b0, 4'h0);
        add(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,        4'd8, 32'h0000_0000, 1'b1, 4'h0);
        add(1'b1, 3'd0, 32'h0000_3FFF, 32'hAAAAAA7F, 4'd9, 32'h0000_0000, 1'b0, 4'h1);
        add(1'b0, 3'd2, 32'h0000_3FFC, 32'h0,        4'd10, 32'h7F000000, 1'b0, 4'h0);

        // ---------------- reset ----------------
        rst        = 1'b1;
        init_mem   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 4'h0;
        resp_ready = 1'b0;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = pat(i);
        @(posedge clk); #1;
        init_mem = 1'b0;
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset resp_valid", 32'(resp_valid), 32'h0);
        chk("reset resp_data", resp_data, 32'h0);
        chk("reset resp_fault", 32'(resp_fault), 32'h0);
        chk("reset resp_rd", 32'(resp_rd), 32'h0);
        chk("reset mem_write_mask", 32'(mem_write_mask), 32'h0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset mem_write_data", mem_write_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, md, mf, mlat, mm);
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd, 0,
                    d, f, r, lat, mcnt, mval, rdy);
            chk($sformatf("vec%0d data", i), d, vecs[i].edata);
            chk($sformatf("vec%0d fault", i), 32'(f), 32'(vecs[i].efault));
            chk($sformatf("vec%0d rd", i), 32'(r), 32'(vecs[i].rd));
            chk($sformatf("vec%0d latency", i), 32'(lat),
                vecs[i].efault ? 32'd1 : vecs[i].we ? 32'd2 : 32'd3);
            chk($sformatf("vec%0d mask cycles", i), 32'(mcnt),
                (vecs[i].emask != 4'h0) ? 32'd1 : 32'd0);
            if (vecs[i].emask != 4'h0) chk($sformatf("vec%0d mask", i), 32'(mval),
                                           32'(vecs[i].emask));
            chk($sformatf("vec%0d idle after", i), 32'(rdy), 32'h1);
        end

        // ---------------- back-pressure ----------------
        model(1'b0, 3'd2, 32'h10, 32'h0, md, mf, mlat, mm);
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_rd = 4'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        // Offer the next request right away; it must wait for the handshake.
        req_funct3 = 3'd4; req_rd = 4'd3;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d resp_valid", k), 32'(resp_valid), 32'h1);
            chk($sformatf("bp%0d resp_data", k), resp_data, md);
            chk($sformatf("bp%0d resp_rd", k), 32'(resp_rd), 32'd9);
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp idle after handshake", 32'(req_ready), 32'h1);
        model(1'b0, 3'd4, 32'h10, 32'h0, md, mf, mlat, mm);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp next accepted", 32'(req_ready), 32'h0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp next data", resp_data, md);
        chk("bp next rd", 32'(resp_rd), 32'd3);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // ---------------- reset during a store in ACCESS ----------------
        model(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, md, mf, mlat, mm);
        run_txn(1'b1, 3'd2, 32'h40, 32'hA5A5A5A5, 4'd1, 0, d, f, r, lat, mcnt, mval, rdy);
        req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst-store mask in access", 32'(mem_write_mask), 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("rst-store mask dropped", 32'(mem_write_mask), 32'h0);
        chk("rst-store req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-store idle after release", 32'(req_ready), 32'h1);
        chk("rst-store no resp", 32'(resp_valid), 32'h0);
        model(1'b0, 3'd2, 32'h40, 32'h0, md, mf, mlat, mm);
        run_txn(1'b0, 3'd2, 32'h40, 32'h0, 4'd2, 0, d, f, r, lat, mcnt, mval, rdy);
        chk("rst-store word unchanged", d, 32'hA5A5A5A5);

        // ---------------- randomized traffic ----------------
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [3:0]  rd;
            int          sel;
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            rd    = 4'($urandom);
            sel   = $urandom_range(0, 9);
            if (sel < 5)      addr = $urandom_range(0, 63);
            else if (sel < 8) addr = $urandom_range(NBYTES - 8, NBYTES + 3);
            else if (sel < 9) addr = $urandom;
            else              addr = $urandom_range(0, NBYTES - 1);
            model(we, f3, addr, wdata, md, mf, mlat, mm);
            run_txn(we, f3, addr, wdata, rd, $urandom_range(0, 2), d, f, r, lat, mcnt, mval, rdy);
            chk($sformatf("rnd%0d data", t), d, md);
            chk($sformatf("rnd%0d fault", t), 32'(f), 32'(mf));
            chk($sformatf("rnd%0d rd", t), 32'(r), 32'(rd));
            chk($sformatf("rnd%0d latency", t), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d mask cycles", t), 32'(mcnt), (mm != 4'h0) ? 32'd1 : 32'd0);
            if (mm != 4'h0) chk($sformatf("rnd%0d mask", t), 32'(mval), 32'(mm));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32E execute stage and memory_group. It is the only master of memory_group's write_mask, addr and write_data.
- Accepts one load/store request at a time over a valid/ready handshake and decodes funct3 into a byte write mask.
- Sequences the single-cycle synchronous memory read, then sign- or zero-extends the load result.
- Returns the result or a fault to writeback over a valid/ready handshake. Misalignment inside the array is resolved by memory_group; out-of-range accesses are resolved here.

Parameters:
- DATA_DEPTH, 4096, words per memory_group bank; must match memory_group.
- ADDR_W, 2+$clog2(DATA_DEPTH), derived local parameter; byte address width into memory_group.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_rd  in  4  destination register tag, passed through unchanged.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  illegal funct3 or out-of-range access.
- resp_rd  out  4  tag of the request being answered.
- mem_write_mask  out  4  to memory_group write_mask.
- mem_addr  out  ADDR_W  to memory_group addr.
- mem_write_data  out  32  to memory_group write_data.
- mem_read_data  in  32  from memory_group read_data; valid one cycle after mem_addr is presented.

Behaviour:
- State machine states: IDLE, ACCESS, LOAD_WAIT, RESP.
- Reset (async): state=IDLE. Outputs: req_ready=1, resp_valid=0, resp_data=0, resp_fault=0, resp_rd=0, mem_write_mask=0, mem_addr=0, mem_write_data=0.
- req_ready=1 only in IDLE. A request is accepted on the edge where req_valid && req_ready; its fields are latched into internal registers.
- Fault check is done at accept:
  - load funct3 in {011,110,111} is a fault;
  - store funct3 > 010 is a fault;
  - addr + size - 1 > 4*DATA_DEPTH - 1 (size 1/2/4) is a fault, including any access wrapping past the top byte;
  - any nonzero req_addr[31:ADDR_W] is a fault.
- State transitions:
  - IDLE -> RESP on accepting a faulting request. No memory access occurs and mem_write_mask stays 0.
  - IDLE -> ACCESS on accepting a legal request.
  - ACCESS: mem_addr = latched addr[ADDR_W-1:0], mem_write_data = latched wdata unshifted.
    - Stores: mem_write_mask = 0001 (SB), 0011 (SH), 1111 (SW), asserted only during ACCESS; the write commits at the edge leaving ACCESS; next state RESP.
    - Loads: mask=0; next state LOAD_WAIT.
  - LOAD_WAIT: mem_addr held. mem_read_data is captured and formatted into resp_data; next state RESP.
  - RESP: resp_valid=1. resp_data, resp_fault and resp_rd are stable until resp_ready=1, then -> IDLE.
- mem_write_mask is 0 in every state except ACCESS for a legal store.
- Load formatting:
  - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
  - LW: [31:0].
- Latency, accept edge to resp_valid: load 3 cycles, store 2 cycles, fault 1 cycle.
- Best-case throughput: one load per 4 cycles, one store per 3 cycles. The next accept is possible in the cycle after the RESP handshake.
- Back-pressure: resp_ready=0 holds RESP indefinitely; no new request is accepted.
- Reset mid-operation: state returns to IDLE asynchronously and mem_write_mask drops to 0 immediately. A store in ACCESS during reset does not write; a pending response is discarded.
- The latched request is never modified by req_* changes after accept.

Test Plan:
- Store SW 0xDEADBEEF at 0x10, then LW 0x10 -> store resp_valid 2 cycles after accept with resp_data=0, fault=0; load resp_data=0xDEADBEEF 3 cycles after accept; mem_write_mask=1111 for exactly one cycle.
- LB at 0x13 after the above store -> resp_data=0xFFFFFFDE. LBU at 0x13 -> 0x000000DE. LHU at 0x11 -> 0x0000ADBE (misaligned, handled by memory_group).
- SH 0xCAFE at 0x3 (misaligned), then LW at 0x0 and LW at 0x4 -> byte 3=0xFE and byte 4=0xCA; surrounding bytes unchanged; mask=0011 in ACCESS.
- LW at 4*DATA_DEPTH-2 (0x3FFE) and LB with funct3=011 -> resp_fault=1 one cycle after accept, resp_data=0, mem_write_mask never asserted, memory contents unchanged.
- Load with resp_ready held low for 5 cycles -> resp_valid, resp_data and resp_rd remain stable and req_ready=0 throughout; on resp_ready=1 the unit returns to IDLE and accepts the next request on the following edge.
- Assert rst while a SW is in ACCESS -> mem_write_mask=0 immediately, the target word unchanged on readback, req_ready=1 after reset releases.
